systolic_feeder: RTL and testbench

- Operand-issue stage directly upstream of the systolic array wrapper.
- Accepts (A column, B row) operand beat pairs over a valid/ready stream and buffers them in a small FIFO.
- Drives the wrapper's enable, last and a/b inputs: one beat per cycle, with last on the K-th beat of each tile.
- After each last, stalls issue for the drain window so the next tile's results do not collide with the drain shift-out.

---
 rtl/common_pkg.sv | 18 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/systolic_feeder.sv | 116 +++++++++++
 tb/tb_systolic_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types for the systolic array datapath: element type, operand pair
// carried through the feeder FIFO, and the feeder FSM encoding.
package common_pkg;

  localparam int DATA_W               = 8;
  localparam int ARRAY_N              = 4;
  localparam int DRAIN_CYCLES_DEFAULT = 2 * ARRAY_N + 3;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic {ISSUE, DRAIN} feeder_fsm_e;

  typedef struct packed {
    data_t [ARRAY_N-1:0] a;
    data_t [ARRAY_N-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; an extra wrap bit on each
// pointer distinguishes full from empty. Storage is not reset.
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_i && !empty_o) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand-issue stage in front of the systolic array: buffers operand pairs,
// issues one beat per cycle with last on the K-th beat, then holds off a drain window.
module systolic_feeder
  import common_pkg::*;
#(
  parameter int SYS_ARRAY_SIZE = ARRAY_N,
  parameter int FIFO_DEPTH     = 4,
  parameter int K_W            = 8,
  parameter int DRAIN_CYCLES   = 2 * SYS_ARRAY_SIZE + 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [K_W-1:0]               k_len_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  data_t [SYS_ARRAY_SIZE-1:0]   in_a_i,
  input  data_t [SYS_ARRAY_SIZE-1:0]   in_b_i,
  output logic                         en_o,
  output logic                         last_o,
  output data_t [SYS_ARRAY_SIZE-1:0]   a_o,
  output data_t [SYS_ARRAY_SIZE-1:0]   b_o,
  output logic                         busy_o,
  output logic                         tile_done_o
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  function automatic logic [K_W-1:0] k_floor1(input logic [K_W-1:0] k);
    return (k == '0) ? K_W'(1) : k;
  endfunction

  feeder_fsm_e    state;
  logic [K_W-1:0] beat_cnt;
  logic [K_W-1:0] k_eff_q;
  logic [DCW-1:0] drain_cnt;

  operand_pair_t  push_data;
  operand_pair_t  head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic [K_W-1:0] k_cur;
  logic           beat_last;

  assign push_data  = '{a: in_a_i, b: in_b_i};
  assign in_ready_o = !fifo_full;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = (state == ISSUE) && !fifo_empty;
  // Tile length is only sampled on the first beat; later beats use the latched copy.
  assign k_cur      = (beat_cnt == '0) ? k_floor1(k_len_i) : k_eff_q;
  assign beat_last  = (beat_cnt == k_cur - K_W'(1));
  assign busy_o     = (beat_cnt != '0) || (state == DRAIN);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (operand_pair_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output register stage: FIFO head -> array operand inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ISSUE;
      beat_cnt    <= '0;
      k_eff_q     <= '0;
      drain_cnt   <= '0;
      en_o        <= 1'b0;
      last_o      <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
      tile_done_o <= 1'b0;
    end else begin
      en_o        <= 1'b0;
      last_o      <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
      tile_done_o <= 1'b0;
      case (state)
        ISSUE: begin
          if (pop) begin
            en_o   <= 1'b1;
            last_o <= beat_last;
            a_o    <= head.a;
            b_o    <= head.b;
            if (beat_cnt == '0) k_eff_q <= k_cur;
            if (beat_last) begin
              beat_cnt  <= '0;
              drain_cnt <= DCW'(DRAIN_CYCLES);
              state     <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + K_W'(1);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - DCW'(1);
          if (drain_cnt == DCW'(1)) begin
            tile_done_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: latency, tile spacing, FIFO backpressure,
// degenerate tile lengths, mid-tile bubbles and asynchronous reset.
module tb_systolic_feeder;
  import common_pkg::*;

  localparam int N = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [7:0]        k_len_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  data_t [N-1:0]     in_a_i = '0;
  data_t [N-1:0]     in_b_i = '0;
  logic              en_o;
  logic              last_o;
  data_t [N-1:0]     a_o;
  data_t [N-1:0]     b_o;
  logic              busy_o;
  logic              tile_done_o;

  int checks = 0;
  int passes = 0;

  systolic_feeder #(
    .SYS_ARRAY_SIZE (N),
    .FIFO_DEPTH     (4),
    .K_W            (8),
    .DRAIN_CYCLES   (2*N+3)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .k_len_i     (k_len_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .en_o        (en_o),
    .last_o      (last_o),
    .a_o         (a_o),
    .b_o         (b_o),
    .busy_o      (busy_o),
    .tile_done_o (tile_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  function automatic logic [N*8-1:0] lanes(input int v);
    logic [N*8-1:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = v[7:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input int av, input int k);
    in_valid_i = v;
    in_a_i     = lanes(av);
    in_b_i     = lanes(av * 10);
    k_len_i    = k[7:0];
  endtask

  task automatic expect_cycle(input string t, input int c, input bit en, input bit last,
                              input bit done, input int av);
    check($sformatf("%s en c%0d", t, c), 32'(en_o), 32'(en));
    check($sformatf("%s last c%0d", t, c), 32'(last_o), 32'(last));
    check($sformatf("%s done c%0d", t, c), 32'(tile_done_o), 32'(done));
    check($sformatf("%s a c%0d", t, c), a_o, en ? lanes(av) : '0);
    check($sformatf("%s b c%0d", t, c), b_o, en ? lanes(av * 10) : '0);
  endtask

  task automatic do_reset(input string t);
    drive(1'b0, 0, 0);
    rst_ni = 1'b0;
    tick();
    tick();
    check({t, " rst en"}, 32'(en_o), 32'd0);
    check({t, " rst last"}, 32'(last_o), 32'd0);
    check({t, " rst ready"}, 32'(in_ready_o), 32'd1);
    check({t, " rst busy"}, 32'(busy_o), 32'd0);
    check({t, " rst done"}, 32'(tile_done_o), 32'd0);
    check({t, " rst a"}, a_o, 32'd0);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nxt;
    bit acc;

    // Single tile k=3: issue at 2,3,4; last at 4; drain ends at 15.
    do_reset("t1");
    for (int c = 0; c < 18; c++) begin
      expect_cycle("t1", c, c >= 2 && c <= 4, c == 4, c == 15, c - 1);
      if (c == 3)  check("t1 busy mid", 32'(busy_o), 32'd1);
      if (c == 10) check("t1 busy drain", 32'(busy_o), 32'd1);
      if (c == 16) check("t1 busy after", 32'(busy_o), 32'd0);
      drive(c < 3, c + 1, 3);
      tick();
    end

    // Two tiles k=2: second tile first beat 12 cycles after first last.
    do_reset("t2");
    for (int c = 0; c < 29; c++) begin
      expect_cycle("t2", c, c == 2 || c == 3 || c == 15 || c == 16, c == 3 || c == 16,
                   c == 14 || c == 27, (c < 10) ? c + 3 : c - 8);
      if (c == 10) check("t2 ready in drain", 32'(in_ready_o), 32'd1);
      drive(c < 4, c + 5, 2);
      tick();
    end

    // FIFO fills during drain: four accepts, then backpressure, in-order issue.
    do_reset("t3");
    nxt = 1;
    for (int c = 0; c < 21; c++) begin
      expect_cycle("t3", c, c == 2 || (c >= 14 && c <= 17), c == 2 || c == 17,
                   c == 13, (c == 2) ? 1 : c - 12);
      if (c == 5)  check("t3 ready before full", 32'(in_ready_o), 32'd1);
      if (c == 6)  check("t3 ready full", 32'(in_ready_o), 32'd0);
      if (c == 13) check("t3 ready still full", 32'(in_ready_o), 32'd0);
      if (c == 14) check("t3 ready after pop", 32'(in_ready_o), 32'd1);
      drive(c == 0 || (c >= 2 && c < 10), nxt, (c < 3) ? 1 : 4);
      acc = in_valid_i && in_ready_o;
      tick();
      if (acc) nxt++;
    end
    check("t3 accepted count", 32'(nxt), 32'd6);

    // k=0 and k=1: each beat is a whole tile.
    do_reset("t4");
    for (int c = 0; c < 27; c++) begin
      expect_cycle("t4", c, c == 2 || c == 14, c == 2 || c == 14,
                   c == 13 || c == 25, (c == 2) ? 1 : 2);
      drive(c < 2, c + 1, (c < 5) ? 0 : 1);
      tick();
    end

    // Bubble mid-tile: beat count survives the gap.
    do_reset("t5");
    for (int c = 0; c < 20; c++) begin
      expect_cycle("t5", c, c == 2 || c == 6 || c == 7, c == 7, c == 18,
                   (c == 2) ? 1 : c - 4);
      if (c == 4) check("t5 busy in bubble", 32'(busy_o), 32'd1);
      drive(c == 0 || c == 4 || c == 5, (c == 0) ? 1 : c - 2, 3);
      tick();
    end

    // Reset during beat 2 of a 4-beat tile discards everything.
    do_reset("t6");
    for (int c = 0; c < 4; c++) begin
      expect_cycle("t6", c, c >= 2, 1'b0, 1'b0, c - 1);
      if (c == 3) break;
      drive(1'b1, c + 1, 4);
      tick();
    end
    drive(1'b1, 4, 4);
    tick();
    drive(1'b0, 0, 4);
    rst_ni = 1'b0;
    #1;
    check("t6 rst en", 32'(en_o), 32'd0);
    check("t6 rst last", 32'(last_o), 32'd0);
    check("t6 rst busy", 32'(busy_o), 32'd0);
    check("t6 rst ready", 32'(in_ready_o), 32'd1);
    check("t6 rst a", a_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int c = 0; c < 9; c++) begin
      expect_cycle("t6 post", c, c == 2, c == 2, 1'b0, 9);
      if (c == 0) check("t6 post busy", 32'(busy_o), 32'd0);
      drive(c == 0, 9, 1);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
